// File: rtl/voice_allocator.sv
// voice_allocator: assigns MIDI note events to synth voices.
// Order of preference for a note-on: same-key retrigger, free voice,
// least-recently-used released voice, then steal the oldest held voice.
//
// state | meaning
// IDLE  | ready for an event; latches key/vel/type on handshake
// SCAN  | examines one voice per cycle, collecting candidates
// ISSUE | one-cycle alloc pulse; voice table updated at end of cycle
module voice_allocator #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input  logic               CLOCK_50,
  input  logic               reset_reg_N,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic               ev_note_on,
  input  logic [6:0]         ev_key,
  input  logic [6:0]         ev_vel,
  input  logic [VOICES-1:0]  voice_free,
  output logic               alloc_valid,
  output logic [V_WIDTH-1:0] alloc_voice,
  output logic [6:0]         alloc_key,
  output logic [6:0]         alloc_vel,
  output logic               alloc_gate,
  output logic               alloc_steal,
  output logic [VOICES-1:0]  keys_on,
  output logic [V_WIDTH:0]   active_keys
);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

  localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);

  state_t               state_q, state_d;
  logic [V_WIDTH-1:0]   scan_idx_q, scan_idx_d;

  logic [6:0]           evt_key_q, evt_key_d;
  logic [6:0]           evt_vel_q, evt_vel_d;
  logic                 evt_on_q, evt_on_d;

  // Candidates: M = same key held, F = free, R = oldest released, O = oldest held
  logic                 m_hit_q, m_hit_d;
  logic [V_WIDTH-1:0]   m_idx_q, m_idx_d;
  logic                 f_hit_q, f_hit_d;
  logic [V_WIDTH-1:0]   f_idx_q, f_idx_d;
  logic                 r_hit_q, r_hit_d;
  logic [V_WIDTH-1:0]   r_idx_q, r_idx_d;
  logic                 o_hit_q, o_hit_d;
  logic [V_WIDTH-1:0]   o_idx_q, o_idx_d;

  logic                 alloc_valid_q, alloc_valid_d;
  logic [V_WIDTH-1:0]   alloc_voice_q, alloc_voice_d;
  logic [6:0]           alloc_key_q, alloc_key_d;
  logic [6:0]           alloc_vel_q, alloc_vel_d;
  logic                 alloc_gate_q, alloc_gate_d;
  logic                 alloc_steal_q, alloc_steal_d;

  logic [6:0]           key_q  [VOICES];
  logic [6:0]           key_d  [VOICES];
  logic [V_WIDTH-1:0]   rank_q [VOICES];
  logic [V_WIDTH-1:0]   rank_d [VOICES];
  logic [VOICES-1:0]    held_q, held_d;
  logic [V_WIDTH:0]     active_keys_q, active_keys_d;

  assign ev_ready    = (state_q == IDLE);
  assign alloc_valid = alloc_valid_q;
  assign alloc_voice = alloc_voice_q;
  assign alloc_key   = alloc_key_q;
  assign alloc_vel   = alloc_vel_q;
  assign alloc_gate  = alloc_gate_q;
  assign alloc_steal = alloc_steal_q;
  assign keys_on     = held_q;
  assign active_keys = active_keys_q;

  // Next-state logic: event latch, per-voice candidate scan and final selection
  always_comb begin
    state_d       = state_q;
    scan_idx_d    = scan_idx_q;
    evt_key_d     = evt_key_q;
    evt_vel_d     = evt_vel_q;
    evt_on_d      = evt_on_q;
    m_hit_d       = m_hit_q;
    m_idx_d       = m_idx_q;
    f_hit_d       = f_hit_q;
    f_idx_d       = f_idx_q;
    r_hit_d       = r_hit_q;
    r_idx_d       = r_idx_q;
    o_hit_d       = o_hit_q;
    o_idx_d       = o_idx_q;
    alloc_valid_d = 1'b0;
    alloc_voice_d = alloc_voice_q;
    alloc_key_d   = alloc_key_q;
    alloc_vel_d   = alloc_vel_q;
    alloc_gate_d  = alloc_gate_q;
    alloc_steal_d = alloc_steal_q;

    unique case (state_q)
      IDLE: begin
        if (ev_valid) begin
          evt_key_d  = ev_key;
          evt_vel_d  = ev_vel;
          // velocity-zero note-on is the running-status form of note-off
          evt_on_d   = ev_note_on && (ev_vel != 7'd0);
          scan_idx_d = '0;
          m_hit_d    = 1'b0;
          m_idx_d    = '0;
          f_hit_d    = 1'b0;
          f_idx_d    = '0;
          r_hit_d    = 1'b0;
          r_idx_d    = '0;
          o_hit_d    = 1'b0;
          o_idx_d    = '0;
          state_d    = SCAN;
        end
      end

      SCAN: begin
        if (held_q[scan_idx_q] && (key_q[scan_idx_q] == evt_key_q) && !m_hit_q) begin
          m_hit_d = 1'b1;
          m_idx_d = scan_idx_q;
        end
        if (!held_q[scan_idx_q] && voice_free[scan_idx_q] && !f_hit_q) begin
          f_hit_d = 1'b1;
          f_idx_d = scan_idx_q;
        end
        if (!held_q[scan_idx_q] && (!r_hit_q || (rank_q[scan_idx_q] > rank_q[r_idx_q]))) begin
          r_hit_d = 1'b1;
          r_idx_d = scan_idx_q;
        end
        if (held_q[scan_idx_q] && (!o_hit_q || (rank_q[scan_idx_q] > rank_q[o_idx_q]))) begin
          o_hit_d = 1'b1;
          o_idx_d = scan_idx_q;
        end

        if (scan_idx_q == LAST_IDX) begin
          if (evt_on_q) begin
            // some voice is always either released (R) or held (O)
            state_d       = ISSUE;
            alloc_valid_d = 1'b1;
            alloc_key_d   = evt_key_q;
            alloc_vel_d   = evt_vel_q;
            alloc_gate_d  = 1'b1;
            alloc_steal_d = 1'b0;
            if (m_hit_d) begin
              alloc_voice_d = m_idx_d;
            end else if (f_hit_d) begin
              alloc_voice_d = f_idx_d;
            end else if (r_hit_d) begin
              alloc_voice_d = r_idx_d;
            end else begin
              alloc_voice_d = o_idx_d;
              alloc_steal_d = 1'b1;
            end
          end else if (m_hit_d) begin
            state_d       = ISSUE;
            alloc_valid_d = 1'b1;
            alloc_voice_d = m_idx_d;
            alloc_key_d   = evt_key_q;
            alloc_vel_d   = evt_vel_q;
            alloc_gate_d  = 1'b0;
            alloc_steal_d = 1'b0;
          end else begin
            // note-off for a key nobody holds: consumed silently
            state_d = IDLE;
          end
        end else begin
          scan_idx_d = scan_idx_q + V_WIDTH'(1);
        end
      end

      ISSUE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Voice table update at the end of ISSUE, plus held-voice popcount
  always_comb begin
    key_d  = key_q;
    rank_d = rank_q;
    held_d = held_q;
    if (state_q == ISSUE) begin
      if (alloc_gate_q) begin
        key_d[alloc_voice_q]  = evt_key_q;
        held_d[alloc_voice_q] = 1'b1;
        // chosen voice becomes newest; everything newer than it ages by one
        for (int i = 0; i < VOICES; i++) begin
          if (rank_q[i] < rank_q[alloc_voice_q]) begin
            rank_d[i] = rank_q[i] + V_WIDTH'(1);
          end
        end
        rank_d[alloc_voice_q] = '0;
      end else begin
        held_d[alloc_voice_q] = 1'b0;
      end
    end

    active_keys_d = '0;
    for (int i = 0; i < VOICES; i++) begin
      active_keys_d = active_keys_d + (V_WIDTH + 1)'(held_d[i]);
    end
  end

  // FSM, event latch, candidate and output registers
  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q       <= IDLE;
      scan_idx_q    <= '0;
      evt_key_q     <= '0;
      evt_vel_q     <= '0;
      evt_on_q      <= 1'b0;
      m_hit_q       <= 1'b0;
      m_idx_q       <= '0;
      f_hit_q       <= 1'b0;
      f_idx_q       <= '0;
      r_hit_q       <= 1'b0;
      r_idx_q       <= '0;
      o_hit_q       <= 1'b0;
      o_idx_q       <= '0;
      alloc_valid_q <= 1'b0;
      alloc_voice_q <= '0;
      alloc_key_q   <= '0;
      alloc_vel_q   <= '0;
      alloc_gate_q  <= 1'b0;
      alloc_steal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      scan_idx_q    <= scan_idx_d;
      evt_key_q     <= evt_key_d;
      evt_vel_q     <= evt_vel_d;
      evt_on_q      <= evt_on_d;
      m_hit_q       <= m_hit_d;
      m_idx_q       <= m_idx_d;
      f_hit_q       <= f_hit_d;
      f_idx_q       <= f_idx_d;
      r_hit_q       <= r_hit_d;
      r_idx_q       <= r_idx_d;
      o_hit_q       <= o_hit_d;
      o_idx_q       <= o_idx_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_voice_q <= alloc_voice_d;
      alloc_key_q   <= alloc_key_d;
      alloc_vel_q   <= alloc_vel_d;
      alloc_gate_q  <= alloc_gate_d;
      alloc_steal_q <= alloc_steal_d;
    end
  end

  // Per-voice key/held/rank table and active count
  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      for (int i = 0; i < VOICES; i++) begin
        key_q[i]  <= '0;
        rank_q[i] <= V_WIDTH'(i);
      end
      held_q        <= '0;
      active_keys_q <= '0;
    end else begin
      key_q         <= key_d;
      rank_q        <= rank_d;
      held_q        <= held_d;
      active_keys_q <= active_keys_d;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed-vector bench for voice_allocator.
module tb_voice_allocator;

  localparam int VOICES  = 8;
  localparam int V_WIDTH = 3;

  logic               CLOCK_50;
  logic               reset_reg_N;
  logic               ev_valid;
  logic               ev_ready;
  logic               ev_note_on;
  logic [6:0]         ev_key;
  logic [6:0]         ev_vel;
  logic [VOICES-1:0]  voice_free;
  logic               alloc_valid;
  logic [V_WIDTH-1:0] alloc_voice;
  logic [6:0]         alloc_key;
  logic [6:0]         alloc_vel;
  logic               alloc_gate;
  logic               alloc_steal;
  logic [VOICES-1:0]  keys_on;
  logic [V_WIDTH:0]   active_keys;

  int checks   = 0;
  int failures = 0;

  voice_allocator #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_reg_N (reset_reg_N),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_note_on  (ev_note_on),
    .ev_key      (ev_key),
    .ev_vel      (ev_vel),
    .voice_free  (voice_free),
    .alloc_valid (alloc_valid),
    .alloc_voice (alloc_voice),
    .alloc_key   (alloc_key),
    .alloc_vel   (alloc_vel),
    .alloc_gate  (alloc_gate),
    .alloc_steal (alloc_steal),
    .keys_on     (keys_on),
    .active_keys (active_keys)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic       note_on;
    logic [6:0] key;
    logic [6:0] vel;
    logic [7:0] free;
    logic       pulse;
    logic [2:0] voice;
    logic       gate;
    logic       steal;
    logic [7:0] keys;
    logic [3:0] active;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int on, input int key, input int vel, input int free,
                              input int pulse, input int voice, input int gate,
                              input int steal, input int keys, input int active);
    vec_t v;
    v.note_on = on[0];
    v.key     = key[6:0];
    v.vel     = vel[6:0];
    v.free    = free[7:0];
    v.pulse   = pulse[0];
    v.voice   = voice[2:0];
    v.gate    = gate[0];
    v.steal   = steal[0];
    v.keys    = keys[7:0];
    v.active  = active[3:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Sends one event and checks the decision; optionally changes voice_free
  // after voice 0 has already been examined.
  task automatic run_vec(input vec_t v, input string name, input bit mid_en,
                         input logic [7:0] mid_free);
    int         waited;
    int         pulse_cnt;
    int         pulse_at;
    int         ready_at;
    logic [2:0] g_voice;
    logic [6:0] g_key;
    logic [6:0] g_vel;
    logic       g_gate;
    logic       g_steal;
    waited = 0;
    @(negedge CLOCK_50);
    while (!ev_ready && waited < 40) begin
      @(negedge CLOCK_50);
      waited++;
    end
    chk({name, "_ready_in"}, 32'(ev_ready), 32'd1);
    ev_valid   = 1'b1;
    ev_note_on = v.note_on;
    ev_key     = v.key;
    ev_vel     = v.vel;
    voice_free = v.free;
    @(posedge CLOCK_50);
    #1 ev_valid = 1'b0;
    pulse_cnt = 0;
    pulse_at  = 0;
    ready_at  = 0;
    g_voice = '0; g_key = '0; g_vel = '0; g_gate = 1'b0; g_steal = 1'b0;
    for (int c = 1; c <= VOICES + 3; c++) begin
      @(negedge CLOCK_50);
      if (mid_en && c == 2) voice_free = mid_free;
      if (alloc_valid) begin
        pulse_cnt++;
        if (pulse_at == 0) begin
          pulse_at = c;
          g_voice  = alloc_voice;
          g_key    = alloc_key;
          g_vel    = alloc_vel;
          g_gate   = alloc_gate;
          g_steal  = alloc_steal;
        end
      end
      if (ev_ready && ready_at == 0) ready_at = c;
    end
    if (v.pulse) begin
      chk({name, "_pulses"},   32'(pulse_cnt), 32'd1);
      chk({name, "_latency"},  32'(pulse_at), 32'(VOICES + 1));
      chk({name, "_voice"},    32'(g_voice), 32'(v.voice));
      chk({name, "_gate"},     32'(g_gate), 32'(v.gate));
      chk({name, "_steal"},    32'(g_steal), 32'(v.steal));
      chk({name, "_key"},      32'(g_key), 32'(v.key));
      chk({name, "_vel"},      32'(g_vel), 32'(v.vel));
      chk({name, "_ready_at"}, 32'(ready_at), 32'(VOICES + 2));
      chk({name, "_key_hold"}, 32'(alloc_key), 32'(v.key));
    end else begin
      chk({name, "_no_pulse"}, 32'(pulse_cnt), 32'd0);
      chk({name, "_ready_at"}, 32'(ready_at), 32'(VOICES + 1));
    end
    chk({name, "_keys_on"}, 32'(keys_on), 32'(v.keys));
    chk({name, "_active"},  32'(active_keys), 32'(v.active));
  endtask

  initial begin
    int pulses;
    reset_reg_N = 1'b0;
    ev_valid    = 1'b0;
    ev_note_on  = 1'b0;
    ev_key      = '0;
    ev_vel      = '0;
    voice_free  = '1;

    //           on key vel  free pul v  g  s  keys  act
    vecs.push_back(mk(1, 60, 100, 'hFF, 1, 0, 1, 0, 'h01, 1));
    vecs.push_back(mk(1, 61, 100, 'hFF, 1, 1, 1, 0, 'h03, 2));
    vecs.push_back(mk(1, 62, 100, 'hFF, 1, 2, 1, 0, 'h07, 3));
    vecs.push_back(mk(1, 63, 100, 'hFF, 1, 3, 1, 0, 'h0F, 4));
    vecs.push_back(mk(1, 64, 100, 'hFF, 1, 4, 1, 0, 'h1F, 5));
    vecs.push_back(mk(1, 65, 100, 'hFF, 1, 5, 1, 0, 'h3F, 6));
    vecs.push_back(mk(1, 66, 100, 'hFF, 1, 6, 1, 0, 'h7F, 7));
    vecs.push_back(mk(1, 67, 100, 'hFF, 1, 7, 1, 0, 'hFF, 8));
    vecs.push_back(mk(1, 70,  90, 'hFF, 1, 0, 1, 1, 'hFF, 8));  // steal oldest
    vecs.push_back(mk(0, 61,  40, 'hFF, 1, 1, 0, 0, 'hFD, 7));
    vecs.push_back(mk(0, 99,  40, 'hFF, 0, 0, 0, 0, 'hFD, 7));  // unknown key
    vecs.push_back(mk(1, 67,  50, 'hFF, 1, 7, 1, 0, 'hFD, 7));  // retrigger beats free
    vecs.push_back(mk(1, 80,  10, 'h00, 1, 1, 1, 0, 'hFF, 8));  // released LRU
    vecs.push_back(mk(0, 62,  20, 'h00, 1, 2, 0, 0, 'hFB, 7));
    vecs.push_back(mk(0, 65,  20, 'h00, 1, 5, 0, 0, 'hDB, 6));
    vecs.push_back(mk(1, 90,  70, 'h00, 1, 2, 1, 0, 'hDF, 7));  // v2 older than v5
    vecs.push_back(mk(0, 90,   5, 'h00, 1, 2, 0, 0, 'hDB, 6));
    vecs.push_back(mk(1, 91,  33, 'h04, 1, 2, 1, 0, 'hDF, 7));  // free beats older v5
    vecs.push_back(mk(1, 92,  44, 'h20, 1, 5, 1, 0, 'hFF, 8));
    vecs.push_back(mk(1, 64,   0, 'h00, 1, 4, 0, 0, 'hEF, 7));  // vel 0 = note-off
    vecs.push_back(mk(0, 70,   1, 'h00, 1, 0, 0, 0, 'hEE, 6));  // stolen voice kept key 70
    vecs.push_back(mk(0, 60,   1, 'h00, 0, 0, 0, 0, 'hEE, 6));  // key 60 was overwritten

    repeat (3) @(negedge CLOCK_50);
    chk("rst_ready",  32'(ev_ready), 32'd1);
    chk("rst_valid",  32'(alloc_valid), 32'd0);
    chk("rst_keys",   32'(keys_on), 32'd0);
    chk("rst_active", 32'(active_keys), 32'd0);
    chk("rst_voice",  32'(alloc_voice), 32'd0);
    reset_reg_N = 1'b1;

    foreach (vecs[i]) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0, 8'h00);
    end

    // Held: all but v0 (rank 4) and v4 (rank 6). v0 is free only when sampled;
    // voice_free drops afterwards, so v0 must still win over older v4.
    run_vec(mk(1, 100, 60, 'h01, 1, 0, 1, 0, 'hEF, 7), "midscan", 1'b1, 8'h00);

    // Reset in the middle of a scan
    @(negedge CLOCK_50);
    ev_valid   = 1'b1;
    ev_note_on = 1'b1;
    ev_key     = 7'd50;
    ev_vel     = 7'd77;
    voice_free = '1;
    @(posedge CLOCK_50);
    #1 ev_valid = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    reset_reg_N = 1'b0;
    #1;
    chk("scanrst_ready",  32'(ev_ready), 32'd1);
    chk("scanrst_valid",  32'(alloc_valid), 32'd0);
    chk("scanrst_keys",   32'(keys_on), 32'd0);
    chk("scanrst_active", 32'(active_keys), 32'd0);
    chk("scanrst_key",    32'(alloc_key), 32'd0);
    @(negedge CLOCK_50);
    reset_reg_N = 1'b1;
    pulses = 0;
    repeat (VOICES + 4) begin
      @(negedge CLOCK_50);
      if (alloc_valid) pulses++;
    end
    chk("scanrst_no_pulse", 32'(pulses), 32'd0);

    // Table and ranks back at reset values
    run_vec(mk(1, 60, 100, 'hFF, 1, 0, 1, 0, 'h01, 1), "post_rst", 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
